// File: rtl/ysyx_24110006_lsu.sv
// Load/store stage: one AXI4-Lite read or write per accepted instruction,
// byte-lane alignment, load extension, bus-wait watchdog and a one-cycle
// writeback pulse.
//
// state | meaning
// IDLE  | waiting for an instruction from execute, o_ready high
// AR    | read address offered, waiting for arready
// R     | rready high, waiting for read data
// AW_W  | write address and data offered, each dropped after its handshake
// B     | bready high, waiting for the write response
// DONE  | o_valid pulse to writeback, then back to IDLE
module ysyx_24110006_lsu #(
  parameter int unsigned TIMEOUT    = 0,
  parameter bit          CHECK_RESP = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_result,
  input  logic [31:0] i_wdata,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [3:0]  i_mem_wmask,
  input  logic [2:0]  i_mem_read_t,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic        o_fault,
  output logic        o_misalign,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_awaddr,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_e;

  // Down-counter start value; terminal count 0 means the limit was reached.
  localparam logic [31:0] WD_LOAD = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  off_q;
  logic [2:0]  read_t_q;
  logic [31:0] pass_q;
  logic [31:0] wd_q;

  logic [1:0]  off_in;
  logic        mis_in;
  logic        wd_fire;
  logic        aw_ok;
  logic        w_ok;

  assign off_in  = i_result[1:0];
  assign wd_fire = (TIMEOUT != 0) && (wd_q == 32'd0);
  assign aw_ok   = !o_awvalid || i_awready;
  assign w_ok    = !o_wvalid || i_wready;

  // Shift the addressed lane down and extend it according to funct3.
  function automatic logic [31:0] load_ext(input logic [31:0] rdata,
                                           input logic [1:0]  off,
                                           input logic [2:0]  rt);
    logic [31:0] s;
    s = rdata >> {off, 3'b000};
    case (rt)
      3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
      3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
      3'b100:  load_ext = {24'd0, s[7:0]};
      3'b101:  load_ext = {16'd0, s[15:0]};
      default: load_ext = s;
    endcase
  endfunction

  // Misalignment of the incoming access, sized by funct3 for loads and wmask for stores.
  always_comb begin
    mis_in = 1'b0;
    if (i_mem_ren) begin
      case (i_mem_read_t[1:0])
        2'b00:   mis_in = 1'b0;
        2'b01:   mis_in = off_in[0];
        default: mis_in = |off_in;
      endcase
    end else if (i_mem_wen) begin
      case (i_mem_wmask)
        4'b0011: mis_in = off_in[0];
        4'b1111: mis_in = |off_in;
        default: mis_in = 1'b0;
      endcase
    end
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      off_q      <= 2'd0;
      read_t_q   <= 3'd0;
      pass_q     <= 32'd0;
      wd_q       <= 32'd0;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_result   <= 32'd0;
      o_fault    <= 1'b0;
      o_misalign <= 1'b0;
      o_araddr   <= 32'd0;
      o_arvalid  <= 1'b0;
      o_rready   <= 1'b0;
      o_awaddr   <= 32'd0;
      o_awvalid  <= 1'b0;
      o_wdata    <= 32'd0;
      o_wstrb    <= 4'd0;
      o_wvalid   <= 1'b0;
      o_bready   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            off_q    <= off_in;
            read_t_q <= i_mem_read_t;
            pass_q   <= i_result;
            o_ready  <= 1'b0;
            wd_q     <= WD_LOAD;
            o_araddr <= {i_result[31:2], 2'b00};
            o_awaddr <= {i_result[31:2], 2'b00};
            o_wdata  <= i_wdata << {off_in, 3'b000};
            o_wstrb  <= i_mem_wmask << off_in;
            if ((i_mem_ren || i_mem_wen) && mis_in) begin
              state_q    <= S_DONE;
              o_valid    <= 1'b1;
              o_result   <= 32'd0;
              o_fault    <= 1'b0;
              o_misalign <= 1'b1;
            end else if (i_mem_ren) begin
              state_q   <= S_AR;
              o_arvalid <= 1'b1;
            end else if (i_mem_wen) begin
              state_q   <= S_AW_W;
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
            end else begin
              state_q    <= S_DONE;
              o_valid    <= 1'b1;
              o_result   <= i_result;
              o_fault    <= 1'b0;
              o_misalign <= 1'b0;
            end
          end
        end
        S_AR, S_R, S_AW_W, S_B: begin
          wd_q <= wd_q - 32'd1;
          if (wd_fire) begin
            state_q    <= S_DONE;
            o_arvalid  <= 1'b0;
            o_rready   <= 1'b0;
            o_awvalid  <= 1'b0;
            o_wvalid   <= 1'b0;
            o_bready   <= 1'b0;
            o_valid    <= 1'b1;
            o_result   <= 32'd0;
            o_fault    <= 1'b1;
            o_misalign <= 1'b0;
          end else if (state_q == S_AR) begin
            if (i_arready) begin
              o_arvalid <= 1'b0;
              o_rready  <= 1'b1;
              state_q   <= S_R;
            end
          end else if (state_q == S_R) begin
            if (i_rvalid) begin
              o_rready   <= 1'b0;
              state_q    <= S_DONE;
              o_valid    <= 1'b1;
              o_misalign <= 1'b0;
              if (CHECK_RESP && (i_rresp != 2'b00)) begin
                o_fault  <= 1'b1;
                o_result <= 32'd0;
              end else begin
                o_fault  <= 1'b0;
                o_result <= load_ext(i_rdata, off_q, read_t_q);
              end
            end
          end else if (state_q == S_AW_W) begin
            if (o_awvalid && i_awready) o_awvalid <= 1'b0;
            if (o_wvalid && i_wready) o_wvalid <= 1'b0;
            if (aw_ok && w_ok) begin
              state_q  <= S_B;
              o_bready <= 1'b1;
            end
          end else begin
            if (i_bvalid) begin
              o_bready   <= 1'b0;
              state_q    <= S_DONE;
              o_valid    <= 1'b1;
              o_misalign <= 1'b0;
              o_result   <= pass_q;
              o_fault    <= CHECK_RESP && (i_bresp != 2'b00);
            end
          end
        end
        S_DONE: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Execute must only pulse i_valid while this stage is idle.
  a_valid_in_idle: assert property (@(posedge i_clock) disable iff (!i_reset_n)
                                    !(i_valid && (state_q != S_IDLE)));

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Directed bench for the load/store stage with a transaction-level model,
// a simple AXI4-Lite responder and one per-cycle compare process.
module tb_ysyx_24110006_lsu;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_result = '0;
  logic [31:0] i_wdata = '0;
  logic        i_mem_ren = 1'b0;
  logic        i_mem_wen = 1'b0;
  logic [3:0]  i_mem_wmask = '0;
  logic [2:0]  i_mem_read_t = '0;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_fault;
  logic        o_misalign;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready = 1'b0;
  logic [31:0] i_rdata = '0;
  logic [1:0]  i_rresp = '0;
  logic        i_rvalid = 1'b0;
  logic        o_rready;
  logic [31:0] o_awaddr;
  logic        o_awvalid;
  logic        i_awready = 1'b0;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_wvalid;
  logic        i_wready = 1'b0;
  logic [1:0]  i_bresp = '0;
  logic        i_bvalid = 1'b0;
  logic        o_bready;

  always #5 i_clock = ~i_clock;

  ysyx_24110006_lsu #(.TIMEOUT(8), .CHECK_RESP(1'b1)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_result(i_result), .i_wdata(i_wdata), .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen),
    .i_mem_wmask(i_mem_wmask), .i_mem_read_t(i_mem_read_t), .o_valid(o_valid),
    .o_result(o_result), .o_fault(o_fault), .o_misalign(o_misalign),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  typedef struct {
    logic        ren, wen;
    logic [3:0]  wmask;
    logic [2:0]  rt;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  rresp, bresp;
    int          ad, rd, awd, wd, bd;
  } op_t;

  typedef struct {
    logic [31:0] result;
    logic        fault, mis, chk_res;
    int          k;
    int          due;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];

  logic [31:0] cur_araddr = '0, cur_awaddr = '0, cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;
  int ar_cyc = 0, aw_cyc = 0, w_cyc = 0;

  int cfg_ad = 0, cfg_rd = 0, cfg_awd = 0, cfg_wd = 0, cfg_bd = 0;
  logic ar_en = 1'b1, r_en = 1'b1, r_force = 1'b0;
  logic [31:0] rdata_c = '0;
  logic [1:0]  rresp_c = '0, bresp_c = '0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk(input logic ren, input logic wen, input logic [3:0] wm,
                             input logic [2:0] rt, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic [1:0] rresp, input logic [1:0] bresp,
                             input int ad, input int rd, input int awd, input int wd, input int bd);
    op_t o;
    o.ren = ren; o.wen = wen; o.wmask = wm; o.rt = rt; o.addr = addr;
    o.wdata = wdata; o.rdata = rdata; o.rresp = rresp; o.bresp = bresp;
    o.ad = ad; o.rd = rd; o.awd = awd; o.wd = wd; o.bd = bd;
    return o;
  endfunction

  function automatic int acc_size(input op_t o);
    if (o.ren) return (o.rt[1:0] == 2'b00) ? 1 : (o.rt[1:0] == 2'b01) ? 2 : 4;
    if (o.wen) return (o.wmask == 4'b0001) ? 1 : (o.wmask == 4'b0011) ? 2 : 4;
    return 1;
  endfunction

  // What writeback must see, from byte-level arithmetic on the access.
  function automatic exp_t model(input op_t o);
    exp_t e;
    int off, size, v;
    logic [7:0] by[4];
    off = int'(o.addr % 4);
    size = acc_size(o);
    e.result = o.addr; e.fault = 1'b0; e.mis = 1'b0; e.chk_res = 1'b1; e.k = 0; e.due = 0;
    if (!o.ren && !o.wen) return e;
    if (off % size != 0) begin
      e.mis = 1'b1; e.result = '0;
      return e;
    end
    if (o.ren) begin
      e.k = o.ad + o.rd + 2;
      if (o.rresp != 2'b00) begin
        e.fault = 1'b1; e.result = '0;
      end else begin
        for (int i = 0; i < 4; i++) by[i] = o.rdata[8*i +: 8];
        if (size == 1) begin
          v = int'(by[off]);
          if (!o.rt[2] && v >= 128) v -= 256;
          e.result = 32'(v);
        end else if (size == 2) begin
          v = int'(by[off]) + 256 * int'(by[off+1]);
          if (!o.rt[2] && v >= 32768) v -= 65536;
          e.result = 32'(v);
        end else begin
          e.result = o.rdata;
        end
      end
    end else begin
      e.k = ((o.awd > o.wd) ? o.awd : o.wd) + o.bd + 2;
      e.fault = (o.bresp != 2'b00);
    end
    return e;
  endfunction

  function automatic logic [3:0] exp_strb(input op_t o);
    logic [3:0] s;
    int off;
    s = '0;
    off = int'(o.addr % 4);
    for (int l = 0; l < 4; l++)
      if (l >= off && l < off + acc_size(o)) s[l] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdat(input op_t o);
    return o.wdata << (8 * int'(o.addr % 4));
  endfunction

  // Responder: each ready/valid comes after the configured number of wait cycles.
  initial begin : slave
    int ar_w, aw_w, w_w, r_w, b_w;
    ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
    forever begin
      @(posedge i_clock);
      #1;
      if (o_arvalid === 1'b1) begin i_arready = ar_en && (ar_w >= cfg_ad); ar_w++; end
      else begin i_arready = 1'b0; ar_w = 0; end
      if (o_awvalid === 1'b1) begin i_awready = (aw_w >= cfg_awd); aw_w++; end
      else begin i_awready = 1'b0; aw_w = 0; end
      if (o_wvalid === 1'b1) begin i_wready = (w_w >= cfg_wd); w_w++; end
      else begin i_wready = 1'b0; w_w = 0; end
      if (o_rready === 1'b1) begin i_rvalid = r_en && (r_w >= cfg_rd); r_w++; end
      else begin i_rvalid = 1'b0; r_w = 0; end
      if (r_force) i_rvalid = 1'b1;
      if (o_bready === 1'b1) begin i_bvalid = (b_w >= cfg_bd); b_w++; end
      else begin i_bvalid = 1'b0; b_w = 0; end
      i_rdata = rdata_c; i_rresp = rresp_c; i_bresp = bresp_c;
    end
  end

  // Per-cycle compare of bus channels and writeback against the model.
  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (o_arvalid === 1'b1) begin ar_cyc++; check32("araddr", o_araddr, cur_araddr); end
      if (o_awvalid === 1'b1) begin aw_cyc++; check32("awaddr", o_awaddr, cur_awaddr); end
      if (o_wvalid === 1'b1) begin
        w_cyc++;
        check32("wdata", o_wdata, cur_wdata);
        check32("wstrb", {28'd0, o_wstrb}, {28'd0, cur_wstrb});
      end
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_valid: o_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check32("valid_cycle", 32'(cyc), 32'(e.due));
          check32("fault", {31'd0, o_fault}, {31'd0, e.fault});
          check32("misalign", {31'd0, o_misalign}, {31'd0, e.mis});
          if (e.chk_res) check32("result", o_result, e.result);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        checks++; errors++;
        $display("FAIL missing_valid: o_valid=0 expected 1 at cycle %0d", exp_q[0].due);
        e = exp_q.pop_front();
      end
    end
  end

  task automatic drive(input op_t o);
    i_result = o.addr; i_wdata = o.wdata; i_mem_ren = o.ren; i_mem_wen = o.wen;
    i_mem_wmask = o.wmask; i_mem_read_t = o.rt; i_valid = 1'b1;
  endtask

  task automatic setup(input op_t o, input logic hang_ar);
    cfg_ad = o.ad; cfg_rd = o.rd; cfg_awd = o.awd; cfg_wd = o.wd; cfg_bd = o.bd;
    ar_en = !hang_ar; r_en = 1'b1;
    rdata_c = o.rdata; rresp_c = o.rresp; bresp_c = o.bresp;
    cur_araddr = o.addr - (o.addr % 4);
    cur_awaddr = cur_araddr;
    cur_wdata = exp_wdat(o);
    cur_wstrb = exp_strb(o);
    ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_op(input op_t o, input logic hang_ar);
    exp_t e;
    e = model(o);
    if (hang_ar) begin e.k = 8; e.fault = 1'b1; e.mis = 1'b0; e.chk_res = 1'b0; end
    setup(o, hang_ar);
    drive(o);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    e.due = cyc + e.k;
    exp_q.push_back(e);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      @(negedge i_clock); #1;
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL completion_timeout: o_valid never seen, expected by cycle %0d", exp_q[0].due);
      exp_q.delete();
    end
    @(posedge i_clock); #1;
    check32("ready_after", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    op_t o;
    exp_t pin;

    // Hand-computed pins on the model itself.
    pin = model(mk(1, 0, 4'b0000, 3'b100, 32'h80000003, 0, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0));
    check32("model_lbu", pin.result, 32'h000000AA);
    pin = model(mk(1, 0, 4'b0000, 3'b001, 32'h80000002, 0, 32'h80010000, 0, 0, 0, 0, 0, 0, 0));
    check32("model_lh", pin.result, 32'hFFFF8001);
    pin = model(mk(1, 0, 4'b0000, 3'b010, 32'h80000002, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check32("model_lw_mis", {31'd0, pin.mis}, 32'd1);
    o = mk(0, 1, 4'b0001, 3'b000, 32'h80000001, 32'h12345678, 0, 0, 0, 0, 0, 2, 0, 0);
    check32("model_sb_wdata", exp_wdat(o), 32'h34567800);
    check32("model_sb_wstrb", {28'd0, exp_strb(o)}, 32'h2);

    // Reset state
    repeat (2) @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    @(negedge i_clock);
    check32("rst_ready", {31'd0, o_ready}, 32'd1);
    check32("rst_valid", {31'd0, o_valid}, 32'd0);
    check32("rst_result", o_result, 32'd0);
    check32("rst_flags", {30'd0, o_fault, o_misalign}, 32'd0);
    check32("rst_bus", {27'd0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 32'd0);
    @(posedge i_clock); #1;

    // Non-memory op
    run_op(mk(0, 0, 4'b0000, 3'b000, 32'h00001234, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check32("nonmem_bus", 32'(ar_cyc + aw_cyc + w_cyc), 32'd0);
    // Load byte unsigned
    run_op(mk(1, 0, 4'b0000, 3'b100, 32'h80000003, 0, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    repeat (3) @(posedge i_clock); #1;
    check32("result_hold", o_result, 32'h000000AA);
    // Load half signed, arready late
    run_op(mk(1, 0, 4'b0000, 3'b001, 32'h80000002, 0, 32'h80010000, 0, 0, 3, 0, 0, 0, 0), 1'b0);
    check32("lh_arvalid_cycles", 32'(ar_cyc), 32'd4);
    // Store byte, awready late
    run_op(mk(0, 1, 4'b0001, 3'b000, 32'h80000001, 32'h12345678, 0, 0, 0, 0, 0, 2, 0, 0), 1'b0);
    check32("sb_wvalid_cycles", 32'(w_cyc), 32'd1);
    check32("sb_awvalid_cycles", 32'(aw_cyc), 32'd3);
    // Misaligned word load
    run_op(mk(1, 0, 4'b0000, 3'b010, 32'h80000002, 0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check32("mis_arvalid_cycles", 32'(ar_cyc), 32'd0);
    // Read error response
    run_op(mk(1, 0, 4'b0000, 3'b010, 32'h80000004, 0, 32'h55667788, 2'b10, 0, 0, 0, 0, 0, 0), 1'b0);
    // More load/store patterns
    run_op(mk(1, 0, 4'b0000, 3'b000, 32'h80000000, 0, 32'h12345680, 0, 0, 0, 2, 0, 0, 0), 1'b0);
    run_op(mk(1, 0, 4'b0000, 3'b101, 32'h80000002, 0, 32'hBEEF0000, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    run_op(mk(1, 0, 4'b0000, 3'b010, 32'h80000008, 0, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0, 0), 1'b0);
    run_op(mk(0, 1, 4'b0011, 3'b000, 32'h80000002, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 3, 1), 1'b0);
    run_op(mk(0, 1, 4'b1111, 3'b000, 32'h80000004, 32'hCAFEF00D, 0, 0, 2'b11, 0, 0, 1, 1, 0), 1'b0);
    run_op(mk(0, 1, 4'b0011, 3'b000, 32'h80000003, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check32("mis_store_bus", 32'(aw_cyc + w_cyc), 32'd0);
    // Load and store both requested: load wins
    run_op(mk(1, 1, 4'b1111, 3'b010, 32'h80000000, 32'h99999999, 32'h01020304, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check32("prio_no_aw", 32'(aw_cyc), 32'd0);
    // Watchdog: arready never comes
    run_op(mk(1, 0, 4'b0000, 3'b010, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    check32("to_arvalid_cycles", 32'(ar_cyc), 32'd8);
    check32("to_arvalid_dropped", {31'd0, o_arvalid}, 32'd0);

    // Reset while waiting in R; a late rvalid must not complete anything
    o = mk(1, 0, 4'b0000, 3'b010, 32'h80000020, 0, 32'h77777777, 0, 0, 0, 0, 0, 0, 0);
    setup(o, 1'b0);
    r_en = 1'b0;
    drive(o);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    @(posedge i_clock); #1;
    check32("rst_mid_rready", {31'd0, o_rready}, 32'd1);
    i_reset_n = 1'b0;
    @(posedge i_clock); #1;
    i_reset_n = 1'b1;
    @(negedge i_clock);
    check32("rst_mid_rready_low", {31'd0, o_rready}, 32'd0);
    check32("rst_mid_ready", {31'd0, o_ready}, 32'd1);
    check32("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    @(posedge i_clock); #1;
    r_force = 1'b1;
    repeat (3) @(posedge i_clock);
    #1 r_force = 1'b0;
    @(negedge i_clock);
    check32("late_rvalid_ready", {31'd0, o_ready}, 32'd1);
    check32("late_rvalid_result", o_result, 32'd0);
    @(posedge i_clock); #1;
    r_en = 1'b1;

    // Recovery after reset
    run_op(mk(0, 0, 4'b0000, 3'b000, 32'hFEEDC0DE, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
